// File: rtl/plab5_mcore_dma_arbiter_pkg.sv
// plab5_mcore_dma_arbiter_pkg: state encodings and memory-message width helpers
// shared by the mcore DMA arbiter and its round-robin sub-arbiter.
package plab5_mcore_dma_arbiter_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ISSUE = 2'd1;
    localparam logic [1:0] STATE_WAIT  = 2'd2;
    localparam logic [1:0] STATE_RESP  = 2'd3;

    localparam int DEFAULT_TIMEOUT = 255;

    // Memory messages carry type(3) + opaque + [addr] + len + data; control excludes data.
    function automatic int len_nbits(input int d);
        return $clog2(d / 8);
    endfunction

    function automatic int req_cnbits(input int o, input int a, input int d);
        return 3 + o + a + len_nbits(d);
    endfunction

    function automatic int resp_cnbits(input int o, input int d);
        return 3 + o + len_nbits(d);
    endfunction

    function automatic int wrap_idx(input int i, input int n);
        return i >= n ? i - n : i;
    endfunction

endpackage

// File: rtl/plab5_mcore_rr_arbiter.sv
// plab5_mcore_rr_arbiter: combinational N-way round-robin priority starting at rr_ptr,
// producing a one-hot grant and its encoded index.
module plab5_mcore_rr_arbiter
    import plab5_mcore_dma_arbiter_pkg::*;
#(
    parameter  int p_num_ports = 4,
    localparam int c_ptr_nbits = $clog2(p_num_ports)
)(
    input  logic [p_num_ports-1:0] req_val,
    input  logic [c_ptr_nbits-1:0] rr_ptr,
    output logic [p_num_ports-1:0] grant,
    output logic [c_ptr_nbits-1:0] grant_idx
);

    logic [c_ptr_nbits-1:0] idx;

    // Scan from farthest to nearest so the port closest to rr_ptr wins last.
    always_comb begin
        idx       = '0;
        grant_idx = '0;
        for (int i = p_num_ports - 1; i >= 0; i--) begin
            idx = c_ptr_nbits'(wrap_idx(int'(rr_ptr) + i, p_num_ports));
            if (req_val[idx])
                grant_idx = idx;
        end
        grant = |req_val ? p_num_ports'(1) << grant_idx : '0;
    end

endmodule

// File: rtl/plab5_mcore_dma_arbiter.sv
// plab5_mcore_dma_arbiter: shares one DMA checker among p_num_ports requesters with
// round-robin grant, one transaction in flight and a watchdog on the checker ack.
module plab5_mcore_dma_arbiter
    import plab5_mcore_dma_arbiter_pkg::*;
#(
    parameter  int p_num_ports    = 4,
    parameter  int p_opaque_nbits = 8,
    parameter  int p_addr_nbits   = 32,
    parameter  int p_data_nbits   = 32,
    parameter  int p_timeout      = DEFAULT_TIMEOUT,
    localparam int c_req_cnbits   = req_cnbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int c_resp_cnbits  = resp_cnbits(p_opaque_nbits, p_data_nbits),
    localparam int c_ptr_nbits    = $clog2(p_num_ports)
)(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_ports-1:0]            req_val,
    output logic [p_num_ports-1:0]            req_rdy,
    input  logic [p_num_ports*p_addr_nbits-1:0] req_src_addr,
    input  logic [p_num_ports*p_addr_nbits-1:0] req_dest_addr,
    input  logic [p_num_ports*c_req_cnbits-1:0] req_control,
    input  logic [p_num_ports-1:0]            req_domain,
    output logic [p_num_ports-1:0]            resp_ack,
    output logic                              resp_err,
    output logic [c_resp_cnbits-1:0]          resp_control,
    output logic                              resp_domain,
    output logic                              chk_val,
    input  logic                              chk_rdy,
    output logic [p_addr_nbits-1:0]           chk_src_addr,
    output logic [p_addr_nbits-1:0]           chk_dest_addr,
    output logic [c_req_cnbits-1:0]           chk_req_control,
    output logic                              chk_domain,
    input  logic                              chk_ack,
    input  logic [c_resp_cnbits-1:0]          chk_resp_control
);

    logic [1:0]               state;
    logic [c_ptr_nbits-1:0]   rr_ptr;
    logic [c_ptr_nbits-1:0]   grant;
    logic [7:0]               timer;
    logic [p_addr_nbits-1:0]  src;
    logic [p_addr_nbits-1:0]  dest;
    logic [c_req_cnbits-1:0]  ctrl;
    logic                     domain;
    logic [c_resp_cnbits-1:0] rctrl;
    logic                     err;

    logic [p_num_ports-1:0]   rr_grant;
    logic [c_ptr_nbits-1:0]   rr_idx;
    logic                     fire;

    logic [p_addr_nbits-1:0]  src_a  [p_num_ports];
    logic [p_addr_nbits-1:0]  dest_a [p_num_ports];
    logic [c_req_cnbits-1:0]  ctrl_a [p_num_ports];

    for (genvar i = 0; i < p_num_ports; i++) begin : g_unpack
        assign src_a[i]  = req_src_addr[i*p_addr_nbits +: p_addr_nbits];
        assign dest_a[i] = req_dest_addr[i*p_addr_nbits +: p_addr_nbits];
        assign ctrl_a[i] = req_control[i*c_req_cnbits +: c_req_cnbits];
    end

    plab5_mcore_rr_arbiter #(.p_num_ports(p_num_ports)) rr_arb (
        .req_val   (req_val),
        .rr_ptr    (rr_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // No handshake is offered while reset is asserted, so nothing fires into a cleared FSM.
    assign req_rdy = (state == STATE_IDLE && reset) ? rr_grant : '0;
    assign fire    = |(req_val & req_rdy);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= STATE_IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            timer  <= '0;
            src    <= '0;
            dest   <= '0;
            ctrl   <= '0;
            domain <= 1'b0;
            rctrl  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: if (fire) begin
                    src    <= src_a[rr_idx];
                    dest   <= dest_a[rr_idx];
                    ctrl   <= ctrl_a[rr_idx];
                    domain <= req_domain[rr_idx];
                    grant  <= rr_idx;
                    state  <= STATE_ISSUE;
                end
                STATE_ISSUE: if (chk_rdy) begin
                    timer <= '0;
                    state <= STATE_WAIT;
                end
                STATE_WAIT: begin
                    // A genuine ack beats the watchdog when both land in the same cycle.
                    if (chk_ack) begin
                        rctrl <= chk_resp_control;
                        err   <= 1'b0;
                        state <= STATE_RESP;
                    end else if (timer == 8'(p_timeout - 1)) begin
                        rctrl <= '0;
                        err   <= 1'b1;
                        state <= STATE_RESP;
                    end else begin
                        timer <= timer == 8'hff ? timer : timer + 8'd1;
                    end
                end
                default: begin
                    rr_ptr <= c_ptr_nbits'(wrap_idx(int'(grant) + 1, p_num_ports));
                    state  <= STATE_IDLE;
                end
            endcase
        end
    end

    assign chk_val         = state == STATE_ISSUE;
    assign chk_src_addr    = chk_val ? src  : '0;
    assign chk_dest_addr   = chk_val ? dest : '0;
    assign chk_req_control = chk_val ? ctrl : '0;
    assign chk_domain      = state != STATE_IDLE && domain;

    assign resp_ack     = state == STATE_RESP ? p_num_ports'(1) << grant : '0;
    assign resp_err     = state == STATE_RESP && err;
    assign resp_control = state == STATE_RESP ? rctrl : '0;
    assign resp_domain  = state != STATE_IDLE && domain;

endmodule

// File: tb/tb_plab5_mcore_dma_arbiter.sv
// tb_plab5_mcore_dma_arbiter: transaction-level randomized bench; a round-robin pointer
// model predicts the winner, the watchdog outcome follows from the chosen ack delay.
module tb_plab5_mcore_dma_arbiter;

    localparam int N  = 4;
    localparam int A  = 32;
    localparam int CQ = 45;
    localparam int CR = 13;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_val = '0;
    logic [N-1:0]      req_rdy;
    logic [N*A-1:0]    req_src_addr = '0;
    logic [N*A-1:0]    req_dest_addr = '0;
    logic [N*CQ-1:0]   req_control = '0;
    logic [N-1:0]      req_domain = '0;
    logic [N-1:0]      resp_ack;
    logic              resp_err;
    logic [CR-1:0]     resp_control;
    logic              resp_domain;
    logic              chk_val;
    logic              chk_rdy = 1'b0;
    logic [A-1:0]      chk_src_addr;
    logic [A-1:0]      chk_dest_addr;
    logic [CQ-1:0]     chk_req_control;
    logic              chk_domain;
    logic              chk_ack = 1'b0;
    logic [CR-1:0]     chk_resp_control = '0;

    int checks = 0;
    int errors = 0;
    int ptr = 0;

    plab5_mcore_dma_arbiter #(.p_num_ports(N), .p_timeout(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_val          (req_val),
        .req_rdy          (req_rdy),
        .req_src_addr     (req_src_addr),
        .req_dest_addr    (req_dest_addr),
        .req_control      (req_control),
        .req_domain       (req_domain),
        .resp_ack         (resp_ack),
        .resp_err         (resp_err),
        .resp_control     (resp_control),
        .resp_domain      (resp_domain),
        .chk_val          (chk_val),
        .chk_rdy          (chk_rdy),
        .chk_src_addr     (chk_src_addr),
        .chk_dest_addr    (chk_dest_addr),
        .chk_req_control  (chk_req_control),
        .chk_domain       (chk_domain),
        .chk_ack          (chk_ack),
        .chk_resp_control (chk_resp_control)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            req_src_addr[i*A +: A]   = $urandom;
            req_dest_addr[i*A +: A]  = $urandom;
            req_control[i*CQ +: CQ]  = CQ'({$urandom, $urandom});
        end
        req_domain = N'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rdy"}, req_rdy, 0);
        check({tag, "_ack"}, resp_ack, 0);
        check({tag, "_chk"}, {chk_val, chk_src_addr, chk_dest_addr}, 0);
        check({tag, "_ctl"}, {chk_req_control, resp_control, resp_err}, 0);
        check({tag, "_dom"}, {chk_domain, resp_domain}, 0);
    endtask

    // ad < TO: ack arrives in WAIT cycle ad; ad >= TO: watchdog fires after TO WAIT cycles.
    task automatic run_txn(input logic [N-1:0] mask, input int stall, input int ad, input bit mid_rst);
        int w;
        int last;
        logic [A-1:0] es, ed;
        logic [CQ-1:0] ec;
        logic edom;
        logic [CR-1:0] rc;
        scramble();
        req_val = mask;
        #1;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && mask[(ptr + k) % N]) w = (ptr + k) % N;
        es   = req_src_addr[w*A +: A];
        ed   = req_dest_addr[w*A +: A];
        ec   = req_control[w*CQ +: CQ];
        edom = req_domain[w];
        check("idle_rdy", req_rdy, 64'(1) << w);
        check("idle_chk_val", chk_val, 0);
        check("idle_dom", {chk_domain, resp_domain}, 0);
        tick();
        req_val = '0;
        scramble();
        #1;
        check("issue_val", chk_val, 1);
        check("issue_src", chk_src_addr, es);
        check("issue_dest", chk_dest_addr, ed);
        check("issue_ctrl", chk_req_control, ec);
        check("issue_dom", chk_domain, edom);
        repeat (stall) begin
            tick();
            check("stall_val", chk_val, 1);
            check("stall_fields", {chk_src_addr, chk_dest_addr}, {es, ed});
            check("stall_noack", resp_ack, 0);
        end
        chk_rdy = 1'b1;
        tick();
        chk_rdy = 1'b0;
        check("wait_val", chk_val, 0);
        check("wait_src", chk_src_addr, 0);
        if (mid_rst) begin
            tick();
            tick();
            reset = 1'b0;
            tick();
            reset = 1'b1;
            ptr = 0;
            #1;
            check_quiet("rst_mid");
            repeat (TO + 2) begin
                tick();
                check("rst_noack", resp_ack, 0);
            end
            return;
        end
        rc = '0;
        last = ad < TO ? ad : TO - 1;
        for (int c = 0; c <= last; c++) begin
            check("wait_noack", resp_ack, 0);
            chk_ack = c == ad;
            chk_resp_control = CR'($urandom);
            if (c == ad) rc = chk_resp_control;
            tick();
            chk_ack = 1'b0;
        end
        #1;
        check("resp_ack", resp_ack, 64'(1) << w);
        check("resp_err", resp_err, ad >= TO);
        check("resp_ctrl", resp_control, ad >= TO ? 0 : rc);
        check("resp_dom", resp_domain, edom);
        check("resp_chk_val", chk_val, 0);
        chk_ack = 1'($urandom);
        chk_resp_control = CR'($urandom);
        tick();
        check("post_ack", resp_ack, 0);
        check("post_ctrl", {resp_control, resp_err}, 0);
        check("post_dom", {chk_domain, resp_domain}, 0);
        chk_ack = 1'b0;
        ptr = (w + 1) % N;
    endtask

    initial begin
        logic [N-1:0] m;
        repeat (3) tick();
        check_quiet("reset");
        reset = 1'b1;
        tick();
        check_quiet("idle_empty");
        run_txn(4'b0100, 0, 2, 1'b0);
        repeat (5) run_txn(4'b1111, 0, 0, 1'b0);
        run_txn(4'b0010, 0, 12, 1'b0);
        run_txn(4'b1001, 0, TO - 1, 1'b0);
        run_txn(4'b1111, 20, 3, 1'b0);
        run_txn(4'b1000, 1, 1, 1'b1);
        run_txn(4'b1111, 0, 1, 1'b0);
        repeat (40) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            run_txn(m, $urandom_range(0, 3), $urandom_range(0, TO + 3), 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
